// File: rtl/regbank_mp.sv
// rtl/regbank_mp.sv - multi-bank register file, two bypassed read ports, one write port, clear sweep
module regbank_mp #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int BANKS  = 2,
    localparam int DEPTH  = 2 ** ADDR_W,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    input  logic [ADDR_W-1:0] DR,
    input  logic [WIDTH-1:0]  DRIN,
    input  logic              LDREG,
    input  logic [BANK_W-1:0] BANKSEL,
    input  logic              LDBANK,
    input  logic              CLR,
    output logic [WIDTH-1:0]  SR1OUT,
    output logic [WIDTH-1:0]  SR2OUT,
    output logic [BANK_W-1:0] ACTBANK,
    output logic              BUSY
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [BANKS][DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [BANK_W-1:0] act_bank;
    logic [BANK_W-1:0] clr_bank;
    logic [BANK_W-1:0] next_bank;
    logic              idle;

    assign idle    = (state == ST_IDLE);
    assign BUSY    = (state == ST_CLEAR);
    assign ACTBANK = act_bank;

    // A sweep requested together with a bank switch targets the newly selected bank.
    assign next_bank = (LDBANK && BANKS > 1) ? BANKSEL : act_bank;

    always_comb begin
        SR1OUT = mem[act_bank][SR1];
        SR2OUT = mem[act_bank][SR2];
        if (idle && LDREG && DR == SR1) SR1OUT = DRIN;
        if (idle && LDREG && DR == SR2) SR2OUT = DRIN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int b = 0; b < BANKS; b++)
                for (int r = 0; r < DEPTH; r++)
                    mem[b][r] <= '0;
            state    <= ST_IDLE;
            cnt      <= '0;
            act_bank <= '0;
            clr_bank <= '0;
        end else if (idle) begin
            if (LDREG) mem[act_bank][DR] <= DRIN;
            act_bank <= next_bank;
            if (CLR) begin
                state    <= ST_CLEAR;
                cnt      <= '0;
                clr_bank <= next_bank;
            end
        end else begin
            mem[clr_bank][cnt] <= '0;
            cnt                <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_regbank_mp.sv
// tb/tb_regbank_mp.sv - randomized and directed self-checking bench for regbank_mp
module tb_regbank_mp;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  SR1, SR2, DR;
    logic [15:0] DRIN;
    logic        LDREG, LDBANK, CLR;
    logic [0:0]  BANKSEL;
    logic [15:0] SR1OUT, SR2OUT;
    logic [0:0]  ACTBANK;
    logic        BUSY;

    regbank_mp #(.WIDTH(16), .ADDR_W(3), .BANKS(2)) dut (
        .CLK(CLK), .RESET(RESET), .SR1(SR1), .SR2(SR2), .DR(DR), .DRIN(DRIN),
        .LDREG(LDREG), .BANKSEL(BANKSEL), .LDBANK(LDBANK), .CLR(CLR),
        .SR1OUT(SR1OUT), .SR2OUT(SR2OUT), .ACTBANK(ACTBANK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: plain arrays and a sweep position counter
    logic [15:0] m [2][8];
    int          m_bank;
    bit          m_busy;
    int          m_pos;
    int          m_sweep_bank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                m[b][r] = 16'h0;
        m_bank = 0; m_busy = 0; m_pos = 0; m_sweep_bank = 0;
    endtask

    function automatic logic [15:0] exp_read(input logic [2:0] a);
        if (!m_busy && LDREG && DR == a) return DRIN;
        return m[m_bank][a];
    endfunction

    task automatic idle_inputs();
        LDREG = 0; LDBANK = 0; CLR = 0; BANKSEL = 0; DR = 0; DRIN = 0; SR1 = 0; SR2 = 0;
    endtask

    // sample half a cycle after the inputs were applied, compare against the model
    task automatic settle();
        #4;
        check("sr1out", {16'h0, SR1OUT}, {16'h0, exp_read(SR1)});
        check("sr2out", {16'h0, SR2OUT}, {16'h0, exp_read(SR2)});
        check("actbank", {31'h0, ACTBANK}, 32'(m_bank));
        check("busy", {31'h0, BUSY}, {31'h0, m_busy});
    endtask

    task automatic edge_step();
        int new_bank;
        @(posedge CLK);
        if (!m_busy) begin
            new_bank = LDBANK ? int'(BANKSEL) : m_bank;
            if (LDREG) m[m_bank][DR] = DRIN;
            m_bank = new_bank;
            if (CLR) begin
                m_busy = 1; m_pos = 0; m_sweep_bank = new_bank;
            end
        end else begin
            m[m_sweep_bank][m_pos] = 16'h0;
            m_pos++;
            if (m_pos == 8) m_busy = 0;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        edge_step();
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        idle_inputs();
        LDREG = 1; DR = a; DRIN = d;
        cyc();
        idle_inputs();
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] e);
        idle_inputs();
        SR1 = a; SR2 = a;
        settle();
        check(tag, {16'h0, SR1OUT}, {16'h0, e});
        edge_step();
    endtask

    initial begin
        idle_inputs();
        RESET = 1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        check("reset_busy", {31'h0, BUSY}, 32'h0);
        check("reset_bank", {31'h0, ACTBANK}, 32'h0);

        // basic writes and reads
        write_reg(3'd3, 16'hA5A5);
        write_reg(3'd5, 16'h0001);
        SR1 = 3; SR2 = 5;
        settle();
        check("rd_r3", {16'h0, SR1OUT}, 32'hA5A5);
        check("rd_r5", {16'h0, SR2OUT}, 32'h0001);
        edge_step();
        for (int r = 0; r < 8; r++)
            if (r != 3 && r != 5) read_check("rd_zero", 3'(r), 16'h0);

        // same-cycle bypass on both ports
        LDREG = 1; DR = 2; DRIN = 16'h1234; SR1 = 2; SR2 = 2;
        settle();
        check("byp_sr1", {16'h0, SR1OUT}, 32'h1234);
        check("byp_sr2", {16'h0, SR2OUT}, 32'h1234);
        edge_step();
        read_check("byp_persist", 3'd2, 16'h1234);

        // bank switch with a same-cycle write going to the old bank
        write_reg(3'd1, 16'h1111);
        LDREG = 1; DR = 1; DRIN = 16'h2222; LDBANK = 1; BANKSEL = 1;
        cyc();
        idle_inputs();
        check("bank_now1", {31'h0, ACTBANK}, 32'h1);
        read_check("bank1_r1_empty", 3'd1, 16'h0);
        write_reg(3'd1, 16'h3333);
        read_check("bank1_r1", 3'd1, 16'h3333);
        LDBANK = 1; BANKSEL = 0;
        cyc();
        idle_inputs();
        read_check("bank0_r1", 3'd1, 16'h2222);

        // fill bank 0, sweep it, drop a mid-sweep write, bank 1 untouched
        for (int r = 0; r < 8; r++) write_reg(3'(r), 16'(16'h0100 + r));
        CLR = 1;
        cyc();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            SR1 = 3'(k); SR2 = 3'((k + 7) % 8);
            if (k == 2) begin LDREG = 1; DR = 4; DRIN = 16'hBEEF; LDBANK = 1; BANKSEL = 1; end
            settle();
            check("sweep_busy", {31'h0, BUSY}, 32'h1);
            check("sweep_pending", {16'h0, SR1OUT}, 32'(16'h0100 + k));
            edge_step();
            idle_inputs();
        end
        check("sweep_done", {31'h0, BUSY}, 32'h0);
        read_check("sweep_r4_dropped", 3'd4, 16'h0);
        for (int r = 0; r < 8; r++) read_check("sweep_zero", 3'(r), 16'h0);
        LDBANK = 1; BANKSEL = 1;
        cyc();
        idle_inputs();
        read_check("bank1_kept", 3'd1, 16'h3333);
        LDBANK = 1; BANKSEL = 0; CLR = 1;
        cyc();
        idle_inputs();

        // reset during sweep cycle 3
        for (int k = 0; k < 3; k++) cyc();
        RESET = 1;
        #1;
        model_reset();
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_bank", {31'h0, ACTBANK}, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 0;
        for (int b = 0; b < 2; b++) begin
            LDBANK = 1; BANKSEL = 1'(b);
            cyc();
            idle_inputs();
            for (int r = 0; r < 8; r++) read_check("rst_zero", 3'(r), 16'h0);
        end
        LDBANK = 1; BANKSEL = 0;
        cyc();

        // CLR with a same-cycle write to the last register
        idle_inputs();
        CLR = 1; LDREG = 1; DR = 7; DRIN = 16'hFFFF;
        cyc();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            SR1 = 7; SR2 = 3'(k);
            settle();
            check("r7_hold", {16'h0, SR1OUT}, 32'hFFFF);
            edge_step();
        end
        read_check("r7_cleared", 3'd7, 16'h0);

        // randomized traffic, including held CLR and bank switches
        for (int i = 0; i < 400; i++) begin
            SR1     = 3'($urandom_range(0, 7));
            SR2     = 3'($urandom_range(0, 7));
            DR      = 3'($urandom_range(0, 7));
            DRIN    = 16'($urandom);
            LDREG   = 1'($urandom_range(0, 1));
            LDBANK  = ($urandom_range(0, 5) == 0);
            BANKSEL = 1'($urandom_range(0, 1));
            CLR     = (i >= 200 && i < 230) ? 1'b1 : ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
